// File: rtl/seq_pattern_det.sv
// Serial pattern detector: overlap/non-overlap matching, input qualifier, sync clear, match counter.
// Define SEQ_DET_CNT_SAT_EN to make match_count saturate instead of wrapping.
module seq_pattern_det #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             inp,
  output logic             match,
  output logic             primed,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } state_t;

  state_t            state_r;
  // Only the newest PAT_W-1 bits can take part in a future match, so the oldest is not kept.
  logic [PAT_W-2:0]  tail_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W-1:0]  window_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              hit_s;

  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt);
`ifdef SEQ_DET_CNT_SAT_EN
    if (&cnt) begin
      count_next = cnt;
    end else begin
      count_next = cnt + CNT_W'(1);
    end
`else
    count_next = cnt + CNT_W'(1);
`endif
  endfunction

  // Candidate window and hit decode for the bit offered this cycle
  always_comb begin
    window_s   = {tail_r, inp};
    fill_inc_s = fill_r + FILL_W'(1);
    if (in_valid && !clear && (state_r == PRIMED) && (window_s == PATTERN)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Detector FSM with history, fill count and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= EMPTY;
      tail_r      <= '0;
      fill_r      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      state_r     <= EMPTY;
      tail_r      <= '0;
      fill_r      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (in_valid) begin
      match <= hit_s;
      case (state_r)
        EMPTY, FILLING: begin
          tail_r  <= window_s[PAT_W-2:0];
          fill_r  <= fill_inc_s;
          state_r <= (fill_inc_s == FILL_LAST) ? PRIMED : FILLING;
        end
        PRIMED: begin
          if (hit_s) begin
            match_count <= count_next(match_count);
            if (OVERLAP == 1'b1) begin
              tail_r <= window_s[PAT_W-2:0];
            end else begin
              // Completing bit is consumed; the next match needs a fresh window
              tail_r  <= '0;
              fill_r  <= '0;
              state_r <= EMPTY;
            end
          end else begin
            tail_r <= window_s[PAT_W-2:0];
          end
        end
        default: begin
          state_r <= EMPTY;
          tail_r  <= '0;
          fill_r  <= '0;
        end
      endcase
    end else begin
      match <= 1'b0;
    end
  end

  assign primed = (state_r == PRIMED);

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed bench for seq_pattern_det: four parameterisations share one stimulus bus.
module tb_seq_pattern_det;

  logic clk, reset, clear, in_valid, inp;
  logic m_ov, p_ov, m_nov, p_nov, m_p2, p_p2, m_c2, p_c2;
  logic [7:0] c_ov, c_nov, c_p2;
  logic [1:0] c_c2;
  int n_checks = 0;
  int n_fail   = 0;

  seq_pattern_det u_ov (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inp(inp),
    .match(m_ov), .primed(p_ov), .match_count(c_ov));

  seq_pattern_det #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inp(inp),
    .match(m_nov), .primed(p_nov), .match_count(c_nov));

  seq_pattern_det #(.PAT_W(2), .PATTERN(2'b01)) u_p2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inp(inp),
    .match(m_p2), .primed(p_p2), .match_count(c_p2));

  seq_pattern_det #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inp(inp),
    .match(m_c2), .primed(p_c2), .match_count(c_c2));

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    inp      = b;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; inp = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; inp = 1'b0;
    #3;
    n_checks++;
    if ({m_ov, p_ov, m_nov, p_nov, m_p2, p_p2, m_c2, p_c2} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {m_ov, p_ov, m_nov, p_nov, m_p2, p_p2, m_c2, p_c2});
    end
    n_checks++;
    if ({c_ov, c_nov, c_p2, c_c2} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h expected 0", {c_ov, c_nov, c_p2, c_c2});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_m;
    bits = 7'b1011011; exp_m = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6-i], 1'b0);
      n_checks++;
      if (m_ov !== exp_m[6-i]) begin
        n_fail++;
        $display("FAIL overlap_match bit%0d: got %b expected %b", i + 1, m_ov, exp_m[6-i]);
      end
    end
    n_checks++;
    if (c_ov !== 8'd2) begin
      n_fail++;
      $display("FAIL overlap_count: got %0d expected 2", c_ov);
    end
    n_checks++;
    if (p_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_primed: got %b expected 1", p_ov);
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits;
    logic [6:0] exp_m;
    bits = 7'b1011011; exp_m = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6-i], 1'b0);
      n_checks++;
      if (m_nov !== exp_m[6-i]) begin
        n_fail++;
        $display("FAIL nonoverlap_match bit%0d: got %b expected %b", i + 1, m_nov, exp_m[6-i]);
      end
      if (i == 3) begin
        n_checks++;
        if (p_nov !== 1'b0) begin
          n_fail++;
          $display("FAIL nonoverlap_refill: primed got %b expected 0", p_nov);
        end
      end
    end
    n_checks++;
    if (c_nov !== 8'd1) begin
      n_fail++;
      $display("FAIL nonoverlap_count: got %0d expected 1", c_nov);
    end
  endtask

  task automatic test_legacy();
    logic [4:0] bits;
    logic [4:0] exp_m;
    bits = 5'b00110; exp_m = 5'b00100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[4-i], 1'b0);
      n_checks++;
      if (m_p2 !== exp_m[4-i]) begin
        n_fail++;
        $display("FAIL legacy_match bit%0d: got %b expected %b", i + 1, m_p2, exp_m[4-i]);
      end
      if (i == 0) begin
        n_checks++;
        if (p_p2 !== 1'b1) begin
          n_fail++;
          $display("FAIL legacy_primed: got %b expected 1", p_p2);
        end
      end
    end
    n_checks++;
    if (c_p2 !== 8'd1) begin
      n_fail++;
      $display("FAIL legacy_count: got %0d expected 1", c_p2);
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({m_ov, p_ov} !== 2'b01) begin
        n_fail++;
        $display("FAIL gap_hold cycle%0d: match,primed got %b expected 01", i, {m_ov, p_ov});
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({m_ov, c_ov} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL gap_hit: match=%b count=%0d expected match=1 count=1", m_ov, c_ov);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({m_ov, c_ov} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL gap_pulse_end: match=%b count=%0d expected match=0 count=1", m_ov, c_ov);
    end
  endtask

  task automatic test_clear();
    logic [5:0] bits;
    bits = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, bits[5-i], 1'b0);
    n_checks++;
    if ({c_ov, p_ov} !== {8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_setup: count=%0d primed=%b expected count=1 primed=1", c_ov, p_ov);
    end
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({m_ov, p_ov, c_ov} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL clear_wins: match=%b primed=%b count=%0d expected 0 0 0", m_ov, p_ov, c_ov);
    end
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({m_ov, p_ov} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_refill: match,primed got %b expected 00", {m_ov, p_ov});
    end
  endtask

  task automatic test_count_wrap();
    logic [15:0] bits;
    logic [15:0] exp_m;
    logic [9:0]  exp_seq;
    int k;
    bits  = 16'b1011011011011011;
    exp_m = 16'b0001001001001001;
`ifdef SEQ_DET_CNT_SAT_EN
    exp_seq = 10'b01_10_11_11_11;
`else
    exp_seq = 10'b01_10_11_00_01;
`endif
    k = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, bits[15-i], 1'b0);
      n_checks++;
      if (m_c2 !== exp_m[15-i]) begin
        n_fail++;
        $display("FAIL cnt_match bit%0d: got %b expected %b", i + 1, m_c2, exp_m[15-i]);
      end
      if (exp_m[15-i]) begin
        n_checks++;
        if (c_c2 !== exp_seq[9-2*k -: 2]) begin
          n_fail++;
          $display("FAIL cnt_value hit%0d: got %0d expected %0d", k + 1, c_c2, exp_seq[9-2*k -: 2]);
        end
        k++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] bits;
    bits = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, bits[5-i], 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({m_ov, p_ov, c_ov} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_async: match=%b primed=%b count=%0d expected 0 0 0", m_ov, p_ov, c_ov);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({m_ov, p_ov, c_ov} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_discard: match=%b primed=%b count=%0d expected 0 0 0", m_ov, p_ov, c_ov);
    end
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_legacy();
    test_gap();
    test_clear();
    test_count_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
